// File: rtl/bat_amateur_harness.sv
// Program-load and OUT-capture controller for the bat_amateur CPU.
// Watchdog logic is built only when BAT_HARNESS_WATCHDOG_EN is defined.
module bat_amateur_harness #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     LOAD_START,
    input  logic [ADDRESS_WIDTH-1:0] LOAD_BASE,
    input  logic [ADDRESS_WIDTH-1:0] LOAD_LEN,
    input  logic [DATA_WIDTH-1:0]    IN_DATA,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    output logic                     HALT,
    output logic                     RAM_WE,
    output logic [DATA_WIDTH-1:0]    DATA_OUT,
    output logic                     DATA_OE,
    output logic [ADDRESS_WIDTH-1:0] ADDRESS,
    input  logic [DATA_WIDTH-1:0]    CPU_OUT,
    input  logic                     CPU_HALT,
    output logic [DATA_WIDTH-1:0]    CAP_DATA,
    output logic                     CAP_VALID,
    input  logic                     CAP_READY,
    output logic                     DONE,
    output logic                     TIMEOUT,
    output logic                     OVERFLOW
);
    // state  | meaning
    // IDLE   | after reset, CPU held, waiting for LOAD_START
    // LOAD   | accepting image words and writing them to RAM
    // RUN    | CPU released, capturing OUT changes
    // FINISH | CPU held again, FIFO still readable, restartable

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if (TIMEOUT_CYCLES < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : g_param_check
        $error("bat_amateur_harness: illegal FIFO_DEPTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_FINISH} state_t;

    state_t                   state_q;
    logic [ADDRESS_WIDTH-1:0] base_q, len_q, count_q, addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic                     we_q, in_ready_q, halt_q, done_q;
    logic                     start, accept, last_word;

    assign start     = LOAD_START && (state_q == S_IDLE || state_q == S_FINISH);
    assign accept    = IN_VALID && in_ready_q;
    assign last_word = (count_q + ADDRESS_WIDTH'(1)) == len_q;

`ifdef BAT_HARNESS_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_next;
    logic            timeout_q;
    assign wd_next = wd_q + WD_W'(1);
    assign TIMEOUT = timeout_q;
`else
    assign TIMEOUT = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            count_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            in_ready_q <= 1'b0;
            halt_q     <= 1'b1;
            done_q     <= 1'b0;
`ifdef BAT_HARNESS_WATCHDOG_EN
            wd_q       <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_FINISH: begin
                    if (LOAD_START) begin
                        base_q  <= LOAD_BASE;
                        len_q   <= LOAD_LEN;
                        count_q <= '0;
                        done_q  <= 1'b0;
`ifdef BAT_HARNESS_WATCHDOG_EN
                        wd_q      <= '0;
                        timeout_q <= 1'b0;
`endif
                        if (LOAD_LEN == '0) begin
                            state_q <= S_RUN;
                            halt_q  <= 1'b0;
                        end else begin
                            state_q    <= S_LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        we_q    <= 1'b1;
                        wdata_q <= IN_DATA;
                        addr_q  <= base_q + count_q;
                        count_q <= count_q + ADDRESS_WIDTH'(1);
                        if (last_word) in_ready_q <= 1'b0;
                    end
                    // Ready already dropped: this strobe is the final write.
                    if (we_q && !in_ready_q) begin
                        state_q <= S_RUN;
                        halt_q  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (CPU_HALT) begin
                        state_q <= S_FINISH;
                        halt_q  <= 1'b1;
                        done_q  <= 1'b1;
                    end
`ifdef BAT_HARNESS_WATCHDOG_EN
                    else if (wd_next == WD_W'(TIMEOUT_CYCLES)) begin
                        state_q   <= S_FINISH;
                        halt_q    <= 1'b1;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                    wd_q <= wd_next;
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign IN_READY = in_ready_q;
    assign HALT     = halt_q;
    assign RAM_WE   = we_q;
    assign DATA_OE  = we_q;
    assign DATA_OUT = wdata_q;
    assign ADDRESS  = addr_q;
    assign DONE     = done_q;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] prev_q;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        occ_q;
    logic                  ovf_q, empty, full, push, pop, push_ok;

    assign empty   = (occ_q == '0);
    assign full    = (occ_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign pop     = !empty && CAP_READY;
    assign push    = (state_q == S_RUN) && (CPU_OUT != prev_q);
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            prev_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
        end else if (start) begin
            prev_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (state_q == S_RUN) prev_q <= CPU_OUT;
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push_ok && !pop) occ_q <= occ_q + (PTR_W + 1)'(1);
            else if (pop && !push_ok) occ_q <= occ_q - (PTR_W + 1)'(1);
            if (push && !push_ok) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_ptr_q] <= CPU_OUT;
    end

    assign CAP_VALID = !empty;
    assign CAP_DATA  = empty ? '0 : mem_q[rd_ptr_q];
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_bat_amateur_harness.sv
// Randomized scoreboard bench for bat_amateur_harness: queue-based reference model,
// independent monitor popping expected RAM writes and FIFO captures.
module tb_bat_amateur_harness;
    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int TMO   = 100;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start;
    logic [AW-1:0] load_base, load_len;
    logic [DW-1:0] in_data;
    logic          in_valid, in_ready, halt, ram_we, data_oe;
    logic [DW-1:0] data_out;
    logic [AW-1:0] address;
    logic [DW-1:0] cpu_out;
    logic          cpu_halt;
    logic [DW-1:0] cap_data;
    logic          cap_valid, cap_ready, done, timeout, overflow;

    bat_amateur_harness #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .FIFO_DEPTH    (DEPTH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK       (clk),
        .RST       (rst_n),
        .LOAD_START(load_start),
        .LOAD_BASE (load_base),
        .LOAD_LEN  (load_len),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .HALT      (halt),
        .RAM_WE    (ram_we),
        .DATA_OUT  (data_out),
        .DATA_OE   (data_oe),
        .ADDRESS   (address),
        .CPU_OUT   (cpu_out),
        .CPU_HALT  (cpu_halt),
        .CAP_DATA  (cap_data),
        .CAP_VALID (cap_valid),
        .CAP_READY (cap_ready),
        .DONE      (done),
        .TIMEOUT   (timeout),
        .OVERFLOW  (overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    int last_we_cyc = -100;

    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    logic [DW-1:0] exp_cap[$];
    logic [DW-1:0] ld_words[$];
    logic [DW-1:0] run_vals[$];
    bit            run_rdy[$];

    logic [DW-1:0] mprev;
    int            mocc;
    bit            movf;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // Monitor: every RAM write and every FIFO pop is matched against the scoreboard.
    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            if (ram_we) begin
                check("data_oe_with_we", data_oe, 1);
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected none", address, data_out);
                end else begin
                    a = exp_addr.pop_front();
                    d = exp_data.pop_front();
                    check("write_addr", address, a);
                    check("write_data", data_out, d);
                end
                last_we_cyc = cyc;
            end
            if (cap_valid && cap_ready) begin
                if (exp_cap.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_capture: got 0x%0h, expected none", cap_data);
                end else begin
                    d = exp_cap.pop_front();
                    check("capture_data", cap_data, d);
                end
            end
        end
    end

    task automatic do_load(input logic [AW-1:0] base, input int len);
        int g;
        int budget;
        @(posedge clk); #1;
        load_start = 1'b1;
        load_base  = base;
        load_len   = AW'(len);
        @(posedge clk); #1;
        load_start = 1'b0;
        if (len == 0) begin
            check("empty_halt_low", halt, 0);
            check("empty_in_ready", in_ready, 0);
            return;
        end
        check("in_ready_rise", in_ready, 1);
        for (int i = 0; i < len; i++) begin
            g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin @(posedge clk); #1; end
            in_valid = 1'b1;
            in_data  = ld_words[i];
            exp_addr.push_back(base + AW'(i));
            exp_data.push_back(ld_words[i]);
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        check("in_ready_after_last", in_ready, 0);
        budget = 0;
        do begin @(negedge clk); budget++; end while (halt !== 1'b0 && budget < 10);
        check("halt_fall", halt, 0);
        check("halt_fall_after_last_we", cyc, last_we_cyc + 1);
        check("writes_all_seen", exp_addr.size(), 0);
    endtask

    task automatic drain;
        cap_ready = 1'b1;
        repeat (DEPTH + 2) begin @(posedge clk); #1; end
        cap_ready = 1'b0;
        check("fifo_drained", cap_valid, 0);
        check("scoreboard_empty", exp_cap.size(), 0);
        check("overflow_flag", overflow, movf);
    endtask

    // Drives run_vals/run_rdy one per cycle, CPU_HALT with the last entry.
    task automatic run_seq;
        int  n;
        bit  chk;
        bit  pop, acc;
        n = run_vals.size();
        mprev = '0; mocc = 0; movf = 1'b0;
        chk = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (chk) check("cap_valid_latency", cap_valid, 1);
            cpu_out   = run_vals[i];
            cap_ready = run_rdy[i];
            cpu_halt  = (i == n - 1);
            pop = (mocc > 0) && run_rdy[i];
            acc = 1'b0;
            if (run_vals[i] != mprev) begin
                if (mocc < DEPTH || pop) begin
                    exp_cap.push_back(run_vals[i]);
                    acc = 1'b1;
                end else movf = 1'b1;
            end
            chk   = acc && (mocc == 0);
            mprev = run_vals[i];
            mocc  = mocc + (acc ? 1 : 0) - (pop ? 1 : 0);
        end
        @(posedge clk); #1;
        if (chk) check("cap_valid_latency", cap_valid, 1);
        cpu_halt  = 1'b0;
        cpu_out   = '0;
        cap_ready = 1'b0;
        check("done_after_halt", done, 1);
        check("halt_in_finish", halt, 1);
        check("timeout_clear", timeout, 0);
        drain();
    endtask

    task automatic halt_only;
        run_vals = {};
        run_rdy  = {};
        run_vals.push_back('0);
        run_rdy.push_back(1'b0);
        run_seq();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int c0;
        int k;
        rst_n = 1'b0; load_start = 1'b0; load_base = '0; load_len = '0;
        in_data = '0; in_valid = 1'b0; cpu_out = '0; cpu_halt = 1'b0; cap_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_halt", halt, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_data_oe", data_oe, 0);
        check("rst_cap_valid", cap_valid, 0);
        check("rst_flags", {done, timeout, overflow}, 0);
        check("rst_data_out", data_out, 0);
        check("rst_address", address, 0);
        check("rst_cap_data", cap_data, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("idle_halt", halt, 1);

        // basic load
        ld_words = {16'h00A1, 16'h00B2, 16'h00C3};
        do_load(16'h0010, 3);
        halt_only();

        // empty image
        do_load(16'h1234, 0);
        halt_only();

        // address wrap
        ld_words = {16'h1111, 16'h2222};
        do_load(16'hFFFF, 2);
        halt_only();

        // capture and halt
        do_load(16'h0000, 0);
        run_vals = {16'd0, 16'd5, 16'd5, 16'd7, 16'd0};
        run_rdy  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_seq();

        // overflow, then a push with simultaneous pop while full
        do_load(16'h0000, 0);
        run_vals = {}; run_rdy = {};
        for (int i = 1; i <= 11; i++) begin
            run_vals.push_back(DW'(i * 3));
            run_rdy.push_back(i == 11);
        end
        run_seq();
        check("overflow_seen", overflow, 1);

        // randomized loads and runs
        for (int t = 0; t < 4; t++) begin
            int len;
            len = $urandom_range(1, 6);
            ld_words = {};
            for (int i = 0; i < len; i++) ld_words.push_back(DW'($urandom));
            do_load(AW'($urandom), len);
            run_vals = {}; run_rdy = {};
            for (int i = 0; i < $urandom_range(20, 40); i++) begin
                run_vals.push_back(DW'($urandom_range(0, 3)));
                run_rdy.push_back($urandom_range(0, 2) == 0);
            end
            run_seq();
        end

        // LOAD_START ignored in RUN, then asynchronous reset mid-run
        do_load(16'h0040, 0);
        @(posedge clk); #1; cpu_out = 16'd9;
        @(posedge clk); #1; cpu_out = 16'd10;
        exp_cap.push_back(16'd9);
        exp_cap.push_back(16'd10);
        @(posedge clk); #1;
        check("cap_valid_before_reset", cap_valid, 1);
        load_start = 1'b1; load_len = 16'd5;
        @(posedge clk); #1;
        load_start = 1'b0;
        check("start_ignored_in_run_ready", in_ready, 0);
        check("start_ignored_in_run_halt", halt, 0);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_halt", halt, 1);
        check("midrun_rst_cap_valid", cap_valid, 0);
        check("midrun_rst_flags", {done, timeout, overflow}, 0);
        exp_cap.delete();
        cpu_out = '0;
        @(negedge clk);
        rst_n = 1'b1;

`ifdef BAT_HARNESS_WATCHDOG_EN
        // watchdog expiry
        do_load(16'h0000, 0);
        c0 = cyc;
        k = 0;
        do begin @(negedge clk); k++; end while (!done && k < 2 * TMO);
        check("wd_done", done, 1);
        check("wd_cycles", cyc - c0, TMO);
        check("wd_timeout", timeout, 1);
        check("wd_halt", halt, 1);
        movf = 1'b0;
        drain();

        // CPU_HALT on the same cycle as expiry wins
        do_load(16'h0000, 0);
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("wd_no_early_done", done, 0);
        cpu_halt = 1'b1;
        @(posedge clk); #1;
        cpu_halt = 1'b0;
        check("tie_done", done, 1);
        check("tie_timeout", timeout, 0);
`else
        do_load(16'h0000, 0);
        c0 = cyc;
        k = 0;
        repeat (TMO + 50) begin @(posedge clk); k++; end
        #1;
        check("nowd_still_running", halt, 0);
        check("nowd_no_done", done, 0);
        check("nowd_no_timeout", timeout, 0);
        halt_only();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/bat_amateur_harness.md
# bat_amateur_harness

Parametrised program-load and output-capture controller for the bat_amateur CPU. It holds the CPU in HALT and streams a program image into RAM over the shared DATA/ADDRESS buses, then releases the CPU. While the CPU runs, it logs every change on the CPU OUT bus into a FIFO and ends the run on CPU halt or on a watchdog timeout. It replaces fixed-width, hand-sequenced stimulus with a reusable block for any bus width and memory depth.

## Interface
- ADDRESS_WIDTH, 16, RAM address bus width
- DATA_WIDTH, 16, data, OUT and capture width
- FIFO_DEPTH, 8, capture FIFO entries; must be a power of 2 and at least 2
- TIMEOUT_CYCLES, 65535, watchdog limit in RUN cycles; must be at least 1
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-low reset
- LOAD_START  in  1  one-cycle pulse that begins a load; LOAD_BASE and LOAD_LEN are latched on it
- LOAD_BASE  in  ADDRESS_WIDTH  first RAM address of the image
- LOAD_LEN  in  ADDRESS_WIDTH  image length in words
- IN_DATA  in  DATA_WIDTH  image word
- IN_VALID  in  1  IN_DATA valid
- IN_READY  out  1  harness accepts a word
- HALT  out  1  holds the CPU and enables RAM access
- RAM_WE  out  1  one-cycle RAM write strobe
- DATA_OUT  out  DATA_WIDTH  write data
- DATA_OE  out  1  drive enable for DATA_OUT onto the shared bus
- ADDRESS  out  ADDRESS_WIDTH  write address
- CPU_OUT  in  DATA_WIDTH  CPU OUT bus
- CPU_HALT  in  1  CPU has executed a halt instruction
- CAP_DATA  out  DATA_WIDTH  FIFO head
- CAP_VALID  out  1  FIFO not empty
- CAP_READY  in  1  pop request
- DONE, TIMEOUT, OVERFLOW  out  1 each  sticky status flags

## Operation
- FSM states: IDLE, LOAD, RUN, FINISH.
- **IDLE** (the reset state):
  - HALT=1.
  - LOAD_START -> LOAD. The same pulse latches base and length, clears count, FIFO, prev register, watchdog and all flags.
- **LOAD**:
  - IN_READY=1.
  - On IN_VALID&&IN_READY, the next cycle drives RAM_WE=1, DATA_OE=1, DATA_OUT=word, ADDRESS=(base+count) mod 2^ADDRESS_WIDTH, and count increments.
  - On acceptance of word number LEN, the state goes to RUN after that write cycle completes.
  - LOAD_LEN=0 skips LOAD: IDLE -> RUN directly, with no writes.
- **RUN**:
  - HALT=0, IN_READY=0, DATA_OE=0.
  - The watchdog increments each cycle.
  - CPU_HALT=1 -> FINISH with DONE=1.
  - Watchdog reaching TIMEOUT_CYCLES -> FINISH with DONE=1 and TIMEOUT=1.
  - If both happen in the same cycle, CPU_HALT wins and TIMEOUT stays 0.
- **FINISH**:
  - HALT=1. The FIFO stays poppable.
  - LOAD_START restarts a load, with the same clearing as IDLE.
- LOAD_START is ignored in LOAD and RUN.
- **Capture**:
  - In RUN, each cycle compares CPU_OUT against prev; prev then loads CPU_OUT.
  - Inequality pushes CPU_OUT into the FIFO. prev is cleared to 0 on LOAD_START, so a first OUT value of 0 is not captured.
- **FIFO** (first-word fall-through):
  - CAP_VALID = !empty and CAP_DATA = head.
  - A pop happens on CAP_VALID&&CAP_READY.
  - A push when full succeeds only if a pop occurs in the same cycle. Otherwise the value is dropped and OVERFLOW sets.
  - Push and pop in the same cycle on a non-full FIFO keeps the occupancy unchanged.
- All counters are modulo their width. The address wraps 2^ADDRESS_WIDTH-1 -> 0 without error.

## Timing
- Reset values:
  - HALT=1.
  - IN_READY, RAM_WE, DATA_OE, CAP_VALID, DONE, TIMEOUT and OVERFLOW are 0.
  - DATA_OUT, ADDRESS and CAP_DATA are 0.
  - State is IDLE.
- Reset asserted mid-operation returns to the reset values immediately (asynchronous): any in-flight write is aborted and the FIFO is emptied.
- IN_READY rises the cycle after LOAD_START.
- Each accepted word produces exactly one RAM_WE cycle one clock later. Back-to-back words give one write per cycle.
- HALT falls the cycle after the final write strobe.
- A CPU_OUT change sampled at edge n gives CAP_VALID=1 after edge n, provided the FIFO was empty.
- DONE rises on the edge that samples CPU_HALT or the timeout; HALT rises on that same edge.

## Configuration
- BAT_HARNESS_WATCHDOG_EN:
  - Defined: watchdog counter and TIMEOUT behave as above.
  - Undefined: no watchdog logic is built, TIMEOUT is tied to 0, and RUN exits only on CPU_HALT.

## Test plan
- **Basic load:** reset, LOAD_BASE=0x0010, LOAD_LEN=3, words 0xA1,0xB2,0xC3 -> RAM_WE at addresses 0x10,0x11,0x12 with matching data; HALT falls one cycle after the third strobe.
- **Empty image:** LOAD_LEN=0 -> no RAM_WE; HALT=0 the cycle after LOAD_START.
- **Address wrap:** LOAD_BASE=0xFFFF, LOAD_LEN=2 -> writes at 0xFFFF then 0x0000.
- **Capture and halt:** in RUN, CPU_OUT sequence 0,5,5,7,0 then CPU_HALT -> FIFO pops 5,7,0; DONE=1, TIMEOUT=0, HALT=1.
- **Overflow:** with FIFO_DEPTH=8 and CAP_READY=0, drive 10 distinct OUT values -> first 8 retained in order, OVERFLOW=1; a push with a simultaneous pop while full is accepted.
- **Watchdog and mid-run reset:**
  - TIMEOUT_CYCLES=100 with CPU_HALT never asserted -> DONE=TIMEOUT=1 exactly 100 RUN cycles after HALT falls (BAT_HARNESS_WATCHDOG_EN defined).
  - RST pulsed mid-RUN -> HALT=1, CAP_VALID=0, all flags 0.
